output_argmax_tracker: RTL and testbench
========================================

# output_argmax_tracker

Streaming argmax and accuracy unit for the output layer. It consumes the `zbyfi` output-layer activations and ideal-output bits produced each clock during a cycle block. At block end it emits the one-hot classification and index of the maximum-activation output neuron, a correct/incorrect flag against the ideal answer, and saturating sample and correct counters. It sits beside `output_layer_block`, driven by the same `cycle_index`, and generalises the top-level max-act logic:

- parametrised lanes and leading garbage cycles;
- final-cycle data included;
- deterministic tie-break;
- built-in accuracy accounting.

## Interface
Parameters:
- `width`, 10: activation bit width, signed two's complement.
- `zbyfi`, 1: output neurons presented per clock (lanes); power of 2.
- `cpc`, 18: clocks per cycle block.
- `skip`, 2: leading garbage cycles per block. `p` must equal `zbyfi*(cpc-skip)`.
- `p`, 16: total output neurons.
- `cntw`, 16: width of the accuracy counters.

Ports:
- `clk`  in  1  clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cycle_index`  in  `$clog2(cpc)`  position within the current cycle block, from `cycle_block_counter`.
- `act_in`  in  `width*zbyfi`  lane k = bits `[width*(k+1)-1 : width*k]`.
- `ans_in`  in  `zbyfi`  ideal-output bit per lane.
- `count_clr`  in  1  synchronous clear of both counters.
- `out_valid`  out  1  one-cycle pulse when a new result is presented.
- `out_onehot`  out  `p`  one-hot of the argmax neuron.
- `out_index`  out  `$clog2(p)`  argmax neuron index.
- `correct`  out  1  `out_index` equals the ideal-answer index.
- `sample_count`  out  `cntw`  number of results produced.
- `correct_count`  out  `cntw`  number of correct results.

## Operation
- **Data cycles.** Cycles with `cycle_index` in `skip..cpc-1` carry data. Cycles `0..skip-1` are ignored entirely.
- **Neuron numbering.** Global neuron index = `(cycle_index-skip)*zbyfi + k`.
- **Per-clock lane max.** Combinational signed comparison across the lanes. On a tie the lowest lane wins.
- **Running max.**
  - Held in a register `smax`/`spos`.
  - Replaced only when the lane max is strictly greater than `smax`, so earlier (lower) indices win ties.
  - `smax` resets to the most negative value `{1'b1,{width-1{1'b0}}}` and `spos` to 0.
  - Consequence: when every value equals the most negative value, the result is index 0.
- **Answer tracking.**
  - Record `apos` = global index of the first lane/cycle in the block with `ans_in`=1, and set a `aseen` flag.
  - Later 1s within the same block are ignored.
- **Block end** (`cycle_index==cpc-1`):
  - The final result includes this cycle's lanes and this cycle's `ans_in`, merged combinationally.
  - Register: `out_index`, `out_onehot = 1<<out_index`, `correct = aseen_final && (apos_final==out_index)`, `out_valid`=1.
  - Then reinitialise `smax`/`spos`/`apos`/`aseen` for the next block.
- **Counters.**
  - On each result, `sample_count`+1, and `correct_count`+1 if `correct`.
  - Both counters saturate at all-ones.
- **`count_clr`.**
  - Zeroes both counters.
  - If asserted in the block-end cycle, clear wins and that sample is not counted.
  - `out_*` are still updated.
- **Reset.**
  - All outputs 0 (`out_valid`, `out_onehot`, `out_index`, `correct`, both counters).
  - Internal state returns to its initial values.
- **Reset mid-block.** The partial block is discarded and no `out_valid` is produced. Tracking resumes from the next data cycle. Normally `cycle_index` also resets to 0.

## Timing
- **Latency.** `out_valid` is high for exactly one clock, in the cycle after the edge at which `cycle_index==cpc-1` is sampled.
- **Result registers** (`out_onehot`, `out_index`, `correct`) update on that same edge and hold until the next block end.
- **Counters** update on the same edge as `out_valid` rises, so they already include the presented result.
- **Throughput.** One result per `cpc` clocks, with no bubbles between back-to-back blocks.
- **Critical path.** `zbyfi`-lane compare tree plus one compare against `smax`. No pipelining is inside the block.

## Test plan
1. **Final-cycle inclusion.** `zbyfi`=1, `p`=16, `cpc`=18. Drive neuron i = i (cycle 2+i). → `out_index`=15, `out_onehot`=16'h8000, `out_valid` pulses once, in the clock after `cycle_index`=17.
2. **Tie-break and garbage cycles.** Neurons 3 and 9 = 10'h0F0, others 10'h010; cycles 0–1 carry 10'h1FF. → `out_index`=3 (garbage ignored, lower index wins).
3. **Most-negative block.** All data = 10'h200. → `out_index`=0, `out_onehot`=16'h0001.
4. **Multi-lane.** `zbyfi`=4, `p`=16, `cpc`=6. Max 10'h100 placed in lane 2 at `cycle_index`=4, lane 3 also 10'h100. → `out_index`=10, `out_onehot` bit 10.
5. **Accuracy counting.**
   - Three blocks: `ans_in` matches the argmax in blocks 1 and 3, mismatches in block 2. → `correct` 1,0,1; `sample_count`=3, `correct_count`=2.
   - Then `count_clr` in a block-end cycle with a correct sample → counts 0,0 and `correct`=1.
   - Counters preloaded to all-ones saturate.
6. **Reset mid-block.** Reset at `cycle_index`=9, with the largest value injected before the reset. → all outputs 0, no `out_valid`. The following full block reports its own argmax, unaffected by pre-reset data.

Source files
------------

// File: rtl/output_argmax_tracker.sv
// Streaming argmax and accuracy tracker for the output layer: finds the strongest output neuron
// over one cycle block, compares it with the ideal answer and keeps saturating counters.
module output_argmax_tracker #(
    parameter int unsigned width = 10,
    parameter int unsigned zbyfi = 1,
    parameter int unsigned cpc   = 18,
    parameter int unsigned skip  = 2,
    parameter int unsigned p     = 16,
    parameter int unsigned cntw  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(cpc)-1:0]   cycle_index,
    input  logic [width*zbyfi-1:0]   act_in,
    input  logic [zbyfi-1:0]         ans_in,
    input  logic                     count_clr,
    output logic                     out_valid,
    output logic [p-1:0]             out_onehot,
    output logic [$clog2(p)-1:0]     out_index,
    output logic                     correct,
    output logic [cntw-1:0]          sample_count,
    output logic [cntw-1:0]          correct_count
);

    localparam int unsigned iw = $clog2(p);
    localparam int unsigned lw = (zbyfi > 1) ? $clog2(zbyfi) : 1;
    localparam logic signed [width-1:0] MostNeg = {1'b1, {(width-1){1'b0}}};

    if (p != zbyfi * (cpc - skip)) begin : g_bad_cfg
        $error("output_argmax_tracker: p must equal zbyfi*(cpc-skip)");
    end

    logic signed [width-1:0] smax_q, smax_d;
    logic [iw-1:0]           spos_q, spos_d;
    logic [iw-1:0]           apos_q, apos_d;
    logic                    aseen_q, aseen_d;

    logic                    out_valid_q;
    logic [p-1:0]            out_onehot_q;
    logic [iw-1:0]           out_index_q;
    logic                    correct_q;
    logic [cntw-1:0]         sample_count_q;
    logic [cntw-1:0]         correct_count_q;

    logic signed [width-1:0] lane_max;
    logic [lw-1:0]           lane_pos;
    logic [lw-1:0]           ans_lane;
    logic                    ans_any;
    logic                    data_cyc;
    logic                    block_end;
    logic [iw-1:0]           base_idx;

    logic signed [width-1:0] cand_max;
    logic [iw-1:0]           cand_pos;
    logic [iw-1:0]           cand_apos;
    logic                    cand_aseen;
    logic                    cand_correct;

    // Lane compare: strict greater-than keeps the lowest lane on ties.
    always_comb begin
        lane_max = $signed(act_in[width-1:0]);
        lane_pos = '0;
        for (int k = 1; k < int'(zbyfi); k++) begin
            if ($signed(act_in[width*k +: width]) > lane_max) begin
                lane_max = $signed(act_in[width*k +: width]);
                lane_pos = lw'(k);
            end
        end
    end

    // Lowest set answer lane in this clock.
    always_comb begin
        ans_any  = |ans_in;
        ans_lane = '0;
        for (int k = int'(zbyfi) - 1; k >= 0; k--) begin
            if (ans_in[k]) begin
                ans_lane = lw'(k);
            end
        end
    end

    always_comb begin
        data_cyc  = (32'(cycle_index) >= skip);
        block_end = (32'(cycle_index) == cpc - 1);
        base_idx  = iw'((32'(cycle_index) - skip) * zbyfi);
    end

    // Merge this clock's lanes into the running state; at block end this is the final result.
    always_comb begin
        cand_max   = smax_q;
        cand_pos   = spos_q;
        cand_apos  = apos_q;
        cand_aseen = aseen_q;
        if (data_cyc) begin
            if (lane_max > smax_q) begin
                cand_max = lane_max;
                cand_pos = base_idx + iw'(lane_pos);
            end
            if (!aseen_q && ans_any) begin
                cand_apos  = base_idx + iw'(ans_lane);
                cand_aseen = 1'b1;
            end
        end
        cand_correct = cand_aseen && (cand_apos == cand_pos);

        smax_d  = cand_max;
        spos_d  = cand_pos;
        apos_d  = cand_apos;
        aseen_d = cand_aseen;
        if (block_end) begin
            smax_d  = MostNeg;
            spos_d  = '0;
            apos_d  = '0;
            aseen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            smax_q          <= MostNeg;
            spos_q          <= '0;
            apos_q          <= '0;
            aseen_q         <= 1'b0;
            out_valid_q     <= 1'b0;
            out_onehot_q    <= '0;
            out_index_q     <= '0;
            correct_q       <= 1'b0;
            sample_count_q  <= '0;
            correct_count_q <= '0;
        end else begin
            smax_q      <= smax_d;
            spos_q      <= spos_d;
            apos_q      <= apos_d;
            aseen_q     <= aseen_d;
            out_valid_q <= block_end;
            if (block_end) begin
                out_index_q  <= cand_pos;
                out_onehot_q <= {{(p-1){1'b0}}, 1'b1} << cand_pos;
                correct_q    <= cand_correct;
            end
            // Clear beats a coincident result, so that sample is dropped from the counts.
            if (count_clr) begin
                sample_count_q  <= '0;
                correct_count_q <= '0;
            end else if (block_end) begin
                if (sample_count_q != '1) begin
                    sample_count_q <= sample_count_q + 1'b1;
                end
                if (cand_correct && (correct_count_q != '1)) begin
                    correct_count_q <= correct_count_q + 1'b1;
                end
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_onehot    = out_onehot_q;
    assign out_index     = out_index_q;
    assign correct       = correct_q;
    assign sample_count  = sample_count_q;
    assign correct_count = correct_count_q;

endmodule

// File: tb/tb_output_argmax_tracker.sv
// Scoreboard bench: drivers push expected block results, per-DUT monitors pop on out_valid.
module tb_output_argmax_tracker;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] oh;
        logic        cor;
        logic [15:0] sc;
        logic [15:0] cc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Instance 0: single lane, default geometry, 16-bit counters.
    logic        reset0, clr0, v0, cor0;
    logic [4:0]  ci0;
    logic [9:0]  act0;
    logic [0:0]  ans0;
    logic [15:0] oh0, sc0, cc0;
    logic [3:0]  idx0;

    // Instance 1: four lanes, six-clock blocks, 2-bit counters to reach saturation quickly.
    logic        reset1, clr1, v1, cor1;
    logic [2:0]  ci1;
    logic [39:0] act1;
    logic [3:0]  ans1;
    logic [15:0] oh1;
    logic [3:0]  idx1;
    logic [1:0]  sc1, cc1;

    output_argmax_tracker dut0 (
        .clk(clk), .reset(reset0), .cycle_index(ci0), .act_in(act0), .ans_in(ans0),
        .count_clr(clr0), .out_valid(v0), .out_onehot(oh0), .out_index(idx0), .correct(cor0),
        .sample_count(sc0), .correct_count(cc0)
    );

    output_argmax_tracker #(
        .width(10), .zbyfi(4), .cpc(6), .skip(2), .p(16), .cntw(2)
    ) dut1 (
        .clk(clk), .reset(reset1), .cycle_index(ci1), .act_in(act1), .ans_in(ans1),
        .count_clr(clr1), .out_valid(v1), .out_onehot(oh1), .out_index(idx1), .correct(cor1),
        .sample_count(sc1), .correct_count(cc1)
    );

    exp_t q0[$];
    exp_t q1[$];
    logic [9:0] v[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] i, input logic [15:0] oh, input logic c,
                                input logic [15:0] s, input logic [15:0] cc);
        exp_t e;
        e.idx = i; e.oh = oh; e.cor = c; e.sc = s; e.cc = cc;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (v0) begin
            if (q0.size() == 0) begin
                tests++; failed++;
                $display("FAIL dut0 unexpected out_valid: got 1, expected 0");
            end else begin
                e = q0.pop_front();
                chk("dut0 out_index", 32'(idx0), 32'(e.idx));
                chk("dut0 out_onehot", 32'(oh0), 32'(e.oh));
                chk("dut0 correct", 32'(cor0), 32'(e.cor));
                chk("dut0 sample_count", 32'(sc0), 32'(e.sc));
                chk("dut0 correct_count", 32'(cc0), 32'(e.cc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (v1) begin
            if (q1.size() == 0) begin
                tests++; failed++;
                $display("FAIL dut1 unexpected out_valid: got 1, expected 0");
            end else begin
                e = q1.pop_front();
                chk("dut1 out_index", 32'(idx1), 32'(e.idx));
                chk("dut1 out_onehot", 32'(oh1), 32'(e.oh));
                chk("dut1 correct", 32'(cor1), 32'(e.cor));
                chk("dut1 sample_count", 32'(sc1), 32'(e.sc));
                chk("dut1 correct_count", 32'(cc1), 32'(e.cc));
            end
        end
    end

    // Garbage cycles carry ans_in=1 and a large value; both must be ignored.
    task automatic block0(input logic [15:0] ansm, input logic [9:0] garb, input logic clr_end,
                          input exp_t e);
        q0.push_back(e);
        for (int c = 0; c < 18; c++) begin
            ci0 = 5'(c);
            if (c < 2) begin
                act0 = garb;
                ans0 = 1'b1;
            end else begin
                act0 = v[c-2];
                ans0 = ansm[c-2];
            end
            clr0 = clr_end && (c == 17);
            @(posedge clk); #1;
        end
        clr0 = 1'b0;
        chk("dut0 valid latency", 32'(v0), 32'd1);
    endtask

    task automatic block1(input logic [15:0] ansm, input exp_t e);
        q1.push_back(e);
        for (int c = 0; c < 6; c++) begin
            ci1 = 3'(c);
            for (int k = 0; k < 4; k++) begin
                if (c < 2) begin
                    act1[10*k +: 10] = 10'h1FF;
                    ans1[k] = 1'b1;
                end else begin
                    act1[10*k +: 10] = v[(c-2)*4+k];
                    ans1[k] = ansm[(c-2)*4+k];
                end
            end
            @(posedge clk); #1;
        end
        chk("dut1 valid latency", 32'(v1), 32'd1);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, " out_valid"}, 32'(v0), 32'd0);
        chk({tag, " out_index"}, 32'(idx0), 32'd0);
        chk({tag, " out_onehot"}, 32'(oh0), 32'd0);
        chk({tag, " correct"}, 32'(cor0), 32'd0);
        chk({tag, " sample_count"}, 32'(sc0), 32'd0);
        chk({tag, " correct_count"}, 32'(cc0), 32'd0);
    endtask

    initial begin
        reset0 = 1'b1; reset1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
        ci0 = '0; act0 = '0; ans0 = '0; ci1 = '0; act1 = '0; ans1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero0("reset");
        chk("reset dut1 sample_count", 32'(sc1), 32'd0);
        reset0 = 1'b0; reset1 = 1'b0;

        // Ramp: final-cycle neuron wins and the answer arrives in the final cycle.
        for (int i = 0; i < 16; i++) v[i] = 10'(i);
        block0(16'h8000, 10'h000, 1'b0, mk(4'd15, 16'h8000, 1'b1, 16'd1, 16'd1));

        // Tie between 3 and 9; first answer bit at 9 (12 ignored) mismatches.
        for (int i = 0; i < 16; i++) v[i] = 10'h010;
        v[3] = 10'h0F0; v[9] = 10'h0F0;
        block0(16'h1200, 10'h1FF, 1'b0, mk(4'd3, 16'h0008, 1'b0, 16'd2, 16'd1));

        // All most-negative: index 0; answer at 0 (5 ignored).
        for (int i = 0; i < 16; i++) v[i] = 10'h200;
        block0(16'h0021, 10'h1FF, 1'b0, mk(4'd0, 16'h0001, 1'b1, 16'd3, 16'd2));

        // count_clr in the block-end cycle of a correct sample.
        for (int i = 0; i < 16; i++) v[i] = 10'(i);
        v[7] = 10'h1F0;
        block0(16'h0080, 10'h000, 1'b1, mk(4'd7, 16'h0080, 1'b1, 16'd0, 16'd0));

        // Reset at cycle_index 9 after injecting the largest value at neuron 5.
        for (int c = 0; c < 9; c++) begin
            ci0 = 5'(c);
            act0 = (c == 7) ? 10'h1FF : 10'h000;
            ans0 = (c == 7);
            @(posedge clk); #1;
        end
        ci0 = 5'd9; act0 = 10'h000; ans0 = 1'b0; reset0 = 1'b1;
        @(posedge clk); #1;
        reset0 = 1'b0;
        chk_zero0("midreset");
        for (int i = 0; i < 16; i++) v[i] = 10'h010;
        v[12] = 10'h050;
        block0(16'h1000, 10'h000, 1'b0, mk(4'd12, 16'h1000, 1'b1, 16'd1, 16'd1));
        ci0 = '0;

        // Multi-lane: tie between lane 2 and lane 3 at cycle 4 -> neuron 10.
        for (int i = 0; i < 16; i++) v[i] = 10'h001;
        v[10] = 10'h100; v[11] = 10'h100;
        block1(16'h0400, mk(4'd10, 16'h0400, 1'b1, 16'd1, 16'd1));
        for (int i = 0; i < 16; i++) v[i] = 10'h3FF;
        v[13] = 10'h0AA;
        block1(16'h0000, mk(4'd13, 16'h2000, 1'b0, 16'd2, 16'd1));
        for (int i = 0; i < 16; i++) v[i] = 10'h200;
        v[15] = 10'h201;
        block1(16'h8000, mk(4'd15, 16'h8000, 1'b1, 16'd3, 16'd2));
        // Counters saturate at 2'b11.
        for (int i = 0; i < 16; i++) v[i] = 10'h000;
        v[0] = 10'h005;
        block1(16'h0001, mk(4'd0, 16'h0001, 1'b1, 16'd3, 16'd3));
        block1(16'h0001, mk(4'd0, 16'h0001, 1'b1, 16'd3, 16'd3));
        ci1 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("dut0 pending results", 32'(q0.size()), 32'd0);
        chk("dut1 pending results", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
